// File: rtl/rom_ctrl_pkg.sv
// Shared types and defaults for the ROM burst arbiter.
package rom_ctrl_pkg;
    localparam int ADDR_W_DEF = 3;
    localparam int DATA_W_DEF = 8;

    typedef enum logic {IDLE, BURST} state_e;

    typedef logic req_id_t;
endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin picker; the last-grant pointer is owned by the caller.
module rr_arb2
    import rom_ctrl_pkg::*;
(
    input  logic    req0_i,
    input  logic    req1_i,
    input  req_id_t last_i,
    output logic    gnt_vld_o,
    output req_id_t win_id_o
);
    assign gnt_vld_o = req0_i | req1_i;
    // On a tie the requester that did not win last time goes first.
    assign win_id_o  = (req0_i & req1_i) ? ~last_i : req1_i;
endmodule

// File: rtl/rom_burst_arbiter.sv
// Shares one combinational ROM between two burst requesters; returned words
// are registered and handed back with valid/done strobes.
module rom_burst_arbiter
    import rom_ctrl_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req0,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] len0,
    output logic              gnt0,
    output logic              vld0,
    output logic [DATA_W-1:0] data0,
    output logic              done0,
    input  logic              req1,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [ADDR_W-1:0] len1,
    output logic              gnt1,
    output logic              vld1,
    output logic [DATA_W-1:0] data1,
    output logic              done1,
    output logic [ADDR_W-1:0] rom_address,
    output logic              rom_sel,
    input  logic [DATA_W-1:0] rom_data,
    output logic              busy
);
    state_e            state_q, state_d;
    req_id_t           owner_q, owner_d;
    req_id_t           last_q, last_d;
    logic [ADDR_W-1:0] cur_addr_q, cur_addr_d;
    logic [ADDR_W-1:0] rem_q, rem_d;
    logic              gnt0_q, gnt0_d, gnt1_q, gnt1_d;
    logic              vld0_q, vld0_d, vld1_q, vld1_d;
    logic              done0_q, done0_d, done1_q, done1_d;
    logic [DATA_W-1:0] data0_q, data0_d, data1_q, data1_d;
    logic              arb_vld;
    req_id_t           arb_id;

    rr_arb2 u_arb (
        .req0_i    (req0),
        .req1_i    (req1),
        .last_i    (last_q),
        .gnt_vld_o (arb_vld),
        .win_id_o  (arb_id)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            owner_q    <= 1'b0;
            last_q     <= 1'b1;
            cur_addr_q <= '0;
            rem_q      <= '0;
            gnt0_q     <= 1'b0;
            gnt1_q     <= 1'b0;
            vld0_q     <= 1'b0;
            vld1_q     <= 1'b0;
            done0_q    <= 1'b0;
            done1_q    <= 1'b0;
            data0_q    <= '0;
            data1_q    <= '0;
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            last_q     <= last_d;
            cur_addr_q <= cur_addr_d;
            rem_q      <= rem_d;
            gnt0_q     <= gnt0_d;
            gnt1_q     <= gnt1_d;
            vld0_q     <= vld0_d;
            vld1_q     <= vld1_d;
            done0_q    <= done0_d;
            done1_q    <= done1_d;
            data0_q    <= data0_d;
            data1_q    <= data1_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        last_d     = last_q;
        cur_addr_d = cur_addr_q;
        rem_d      = rem_q;
        gnt0_d     = 1'b0;
        gnt1_d     = 1'b0;
        vld0_d     = 1'b0;
        vld1_d     = 1'b0;
        done0_d    = 1'b0;
        done1_d    = 1'b0;
        data0_d    = data0_q;
        data1_d    = data1_q;
        case (state_q)
            IDLE: begin
                if (arb_vld) begin
                    state_d    = BURST;
                    owner_d    = arb_id;
                    last_d     = arb_id;
                    cur_addr_d = arb_id ? addr1 : addr0;
                    rem_d      = arb_id ? len1 : len0;
                    gnt0_d     = ~arb_id;
                    gnt1_d     = arb_id;
                end
            end
            BURST: begin
                cur_addr_d = cur_addr_q + ADDR_W'(1);
                rem_d      = rem_q - ADDR_W'(1);
                if (owner_q) begin
                    data1_d = rom_data;
                    vld1_d  = 1'b1;
                    done1_d = (rem_q == '0);
                end else begin
                    data0_d = rom_data;
                    vld0_d  = 1'b1;
                    done0_d = (rem_q == '0);
                end
                // Returning to IDLE forces the one-cycle gap between bursts.
                if (rem_q == '0) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign rom_sel     = (state_q == BURST);
    assign rom_address = rom_sel ? cur_addr_q : '0;
    assign busy        = rom_sel;
    assign gnt0        = gnt0_q;
    assign gnt1        = gnt1_q;
    assign vld0        = vld0_q;
    assign vld1        = vld1_q;
    assign done0       = done0_q;
    assign done1       = done1_q;
    assign data0       = data0_q;
    assign data1       = data1_q;
endmodule

// File: tb/tb_rom_burst_arbiter.sv
// Directed bench for rom_burst_arbiter; ROM model returns address + 1.
module tb_rom_burst_arbiter;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       req0 = 1'b0, req1 = 1'b0;
    logic [2:0] addr0 = '0, len0 = '0, addr1 = '0, len1 = '0;
    logic       gnt0, vld0, done0, gnt1, vld1, done1;
    logic [7:0] data0, data1;
    logic [2:0] rom_address;
    logic       rom_sel, busy;
    logic [7:0] rom_data;
    int         errors = 0;
    int         checks = 0;

    always #5 clk = ~clk;
    assign rom_data = {5'd0, rom_address} + 8'd1;

    rom_burst_arbiter dut (
        .clk(clk), .rst_n(rst_n),
        .req0(req0), .addr0(addr0), .len0(len0),
        .gnt0(gnt0), .vld0(vld0), .data0(data0), .done0(done0),
        .req1(req1), .addr1(addr1), .len1(len1),
        .gnt1(gnt1), .vld1(vld1), .data1(data1), .done1(done1),
        .rom_address(rom_address), .rom_sel(rom_sel), .rom_data(rom_data),
        .busy(busy)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [7:0] w2 [4];
        logic [2:0] a2 [4];
        w2[0] = 8'd7; w2[1] = 8'd8; w2[2] = 8'd1; w2[3] = 8'd2;
        a2[0] = 3'd7; a2[1] = 3'd0; a2[2] = 3'd1; a2[3] = 3'd1;

        // Reset state
        #2;
        chk("rst_gnt", {gnt0, gnt1, vld0, vld1, done0, done1}, 0);
        chk("rst_rom", {busy, rom_sel, rom_address}, 0);
        chk("rst_data", {data0, data1}, 0);
        cyc();
        rst_n = 1'b1;

        // 1: single word from address 2
        req0 = 1'b1; addr0 = 3'd2; len0 = 3'd0;
        cyc();
        chk("t1_gnt0", {gnt0, gnt1, vld0}, 3'b100);
        chk("t1_rom", {busy, rom_sel, rom_address}, {2'b11, 3'd2});
        req0 = 1'b0;
        cyc();
        chk("t1_vld", {vld0, done0, gnt0, vld1}, 4'b1100);
        chk("t1_data0", data0, 8'd3);
        chk("t1_idle", {busy, rom_sel, rom_address}, 0);

        // 2: wrapping burst 6,7,0,1 for requester 1
        req1 = 1'b1; addr1 = 3'd6; len1 = 3'd3;
        cyc();
        chk("t2_gnt1", {gnt1, gnt0}, 2'b10);
        chk("t2_addr0", {rom_sel, rom_address}, {1'b1, 3'd6});
        req1 = 1'b0;
        for (int k = 0; k < 4; k++) begin
            cyc();
            chk("t2_vld1", {vld1, vld0, done1}, {2'b10, (k == 3)});
            chk("t2_data1", data1, w2[k]);
            if (k < 3) chk("t2_addr", {rom_sel, rom_address}, {1'b1, a2[k]});
            else       chk("t2_idle", {rom_sel, rom_address}, 0);
        end
        chk("t2_data0_hold", data0, 8'd3);

        // 3: both requesting, len 0: grants alternate with an idle gap
        req0 = 1'b1; addr0 = 3'd3; len0 = 3'd0;
        req1 = 1'b1; addr1 = 3'd5; len1 = 3'd0;
        for (int i = 0; i < 4; i++) begin
            cyc();
            chk("t3_gnt", {gnt0, gnt1, rom_sel}, {(i % 2 == 0), (i % 2 == 1), 1'b1});
            cyc();
            chk("t3_gap", {rom_sel, vld0, vld1}, {1'b0, (i % 2 == 0), (i % 2 == 1)});
            if (i % 2 == 0) chk("t3_data0", data0, 8'd4);
            else            chk("t3_data1", data1, 8'd6);
        end
        req0 = 1'b0; req1 = 1'b0;

        // 4: req1 raised mid-burst of requester 0
        req0 = 1'b1; addr0 = 3'd1; len0 = 3'd4;
        cyc();
        chk("t4_gnt0", {gnt0, gnt1}, 2'b10);
        req0 = 1'b0;
        req1 = 1'b1; addr1 = 3'd0; len1 = 3'd0;
        for (int k = 0; k < 5; k++) begin
            cyc();
            chk("t4_burst0", {vld0, done0, vld1, gnt1}, {1'b1, (k == 4), 2'b00});
            chk("t4_data0", data0, 8'(k + 2));
        end
        cyc();
        chk("t4_gnt1", {gnt1, gnt0, vld0, vld1}, 4'b1000);
        req1 = 1'b0;
        cyc();
        chk("t4_vld1", {vld1, done1, vld0}, 3'b110);
        chk("t4_data1", data1, 8'd1);

        // 5: reset mid-burst
        req0 = 1'b1; addr0 = 3'd0; len0 = 3'd7;
        cyc();
        chk("t5_gnt0", gnt0, 1'b1);
        req0 = 1'b0;
        cyc();
        chk("t5_w0", {vld0, data0}, {1'b1, 8'd1});
        cyc();
        chk("t5_w1", {vld0, data0}, {1'b1, 8'd2});
        rst_n = 1'b0;
        #1;
        chk("t5_rst_out", {gnt0, gnt1, vld0, vld1, done0, done1, busy, rom_sel, rom_address}, 0);
        chk("t5_rst_data", {data0, data1}, 0);
        req0 = 1'b1; addr0 = 3'd4; len0 = 3'd0;
        req1 = 1'b1; addr1 = 3'd2; len1 = 3'd0;
        #3;
        rst_n = 1'b1;
        cyc();
        chk("t5_gnt0_first", {gnt0, gnt1, rom_address}, {2'b10, 3'd4});
        cyc();
        chk("t5_vld0", {vld0, done0, data0}, {2'b11, 8'd5});
        cyc();
        chk("t5_gnt1", {gnt1, gnt0}, 2'b10);
        req0 = 1'b0; req1 = 1'b0;
        cyc();
        chk("t5_vld1", {vld1, done1, data1}, {2'b11, 8'd3});

        // 6: full 8-word burst, no ninth access
        req0 = 1'b1; addr0 = 3'd0; len0 = 3'd7;
        cyc();
        chk("t6_gnt0", {gnt0, rom_sel, rom_address}, {2'b11, 3'd0});
        req0 = 1'b0;
        for (int k = 0; k < 8; k++) begin
            cyc();
            chk("t6_word", {vld0, done0, data0}, {1'b1, (k == 7), 8'(k + 1)});
        end
        chk("t6_end", {busy, rom_sel, rom_address}, 0);
        cyc();
        chk("t6_quiet", {vld0, done0, busy, rom_sel, rom_address}, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
